// File: rtl/branch_fu_queue_if.sv
// Issue/complete-side bundle for the branch functional unit queue.
// BRANCH_FU_PREDICT_EN adds the prediction inputs and the mispredict output.
interface branch_fu_queue_if #(
  parameter int XLEN  = 32,
  parameter int ROB_W = 5,
  parameter int PR_W  = 6
);
  logic             in_valid;
  logic [2:0]       in_func;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_npc;
  logic [XLEN-1:0]  in_imm;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [PR_W-1:0]  in_dest_pr;
  logic [ROB_W-1:0] in_rob_entry;
  logic             in_halt;
  logic             in_ready;
  logic             flush;
  logic             complete_stall;
  logic             out_valid;
  logic             out_take_branch;
  logic [XLEN-1:0]  out_target_pc;
  logic [XLEN-1:0]  out_dest_value;
  logic [PR_W-1:0]  out_dest_pr;
  logic [ROB_W-1:0] out_rob_entry;
  logic             out_halt;
`ifdef BRANCH_FU_PREDICT_EN
  logic             in_pred_taken;
  logic [XLEN-1:0]  in_pred_target;
  logic             out_mispredict;
`endif

  modport slave (
    input  in_valid, in_func, in_pc, in_npc, in_imm, in_rs1, in_rs2,
           in_dest_pr, in_rob_entry, in_halt, flush, complete_stall,
    output in_ready, out_valid, out_take_branch, out_target_pc, out_dest_value,
           out_dest_pr, out_rob_entry, out_halt
`ifdef BRANCH_FU_PREDICT_EN
    , input in_pred_taken, in_pred_target
    , output out_mispredict
`endif
  );

  modport master (
    output in_valid, in_func, in_pc, in_npc, in_imm, in_rs1, in_rs2,
           in_dest_pr, in_rob_entry, in_halt, flush, complete_stall,
    input  in_ready, out_valid, out_take_branch, out_target_pc, out_dest_value,
           out_dest_pr, out_rob_entry, out_halt
`ifdef BRANCH_FU_PREDICT_EN
    , output in_pred_taken, in_pred_target
    , input out_mispredict
`endif
  );
endinterface

// File: rtl/branch_fu_queue.sv
// Branch FU: resolves BRANCH/JAL/JALR at accept and queues results in order for complete.
// Optional prediction checking is enabled by defining BRANCH_FU_PREDICT_EN.
module branch_fu_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int ROB_W = 5,
  parameter int PR_W  = 6
) (
  input  logic              clock,
  input  logic              reset,
  branch_fu_queue_if.slave  bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  logic [PTR_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_vld, w_acc, w_deq;

  logic signed [XLEN-1:0] w_rs1_s, w_rs2_s;
  logic                   w_take, w_jalr, w_link;
  logic [XLEN-1:0]        w_sum, w_target, w_dval;

  logic             r_take   [DEPTH];
  logic [XLEN-1:0]  r_target [DEPTH];
  logic [XLEN-1:0]  r_dval   [DEPTH];
  logic [PR_W-1:0]  r_dpr    [DEPTH];
  logic [ROB_W-1:0] r_rob    [DEPTH];
  logic             r_halt   [DEPTH];

  assign w_vld = (r_count != '0);
  assign bus.in_ready = (r_count != FULL);
  // Flush suppresses both ends; a head visible during flush is not completed.
  assign w_acc = bus.in_valid & bus.in_ready & ~bus.flush;
  assign w_deq = w_vld & ~bus.complete_stall & ~bus.flush;

  // Resolve stage: condition, target and link value computed in the accept cycle
  assign w_rs1_s = bus.in_rs1;
  assign w_rs2_s = bus.in_rs2;

  always_comb begin
    w_take = 1'b1;
    case (bus.in_func)
      3'd0:    w_take = (bus.in_rs1 == bus.in_rs2);
      3'd1:    w_take = (bus.in_rs1 != bus.in_rs2);
      3'd4:    w_take = (w_rs1_s < w_rs2_s);
      3'd5:    w_take = (w_rs1_s >= w_rs2_s);
      3'd6:    w_take = (bus.in_rs1 < bus.in_rs2);
      3'd7:    w_take = (bus.in_rs1 >= bus.in_rs2);
      default: w_take = 1'b1;
    endcase
    w_jalr   = (bus.in_func == 3'd3);
    w_link   = (bus.in_func == 3'd2) | w_jalr;
    w_sum    = (w_jalr ? bus.in_rs1 : bus.in_pc) + bus.in_imm;
    w_target = w_jalr ? {w_sum[XLEN-1:1], 1'b0} : (w_take ? w_sum : bus.in_npc);
    w_dval   = w_link ? bus.in_npc : '0;
  end

  // Queue stage: control state is reset, payload is only written on accept
  always_ff @(posedge clock) begin
    if (reset || bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_acc) r_tail <= f_next(r_tail);
      if (w_deq) r_head <= f_next(r_head);
      case ({w_acc, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_acc) begin
      r_take[r_tail]   <= w_take;
      r_target[r_tail] <= w_target;
      r_dval[r_tail]   <= w_dval;
      r_dpr[r_tail]    <= bus.in_dest_pr;
      r_rob[r_tail]    <= bus.in_rob_entry;
      r_halt[r_tail]   <= bus.in_halt;
    end
  end

  // Complete stage: head fields, forced to zero while empty
  assign bus.out_valid       = w_vld;
  assign bus.out_take_branch = w_vld ? r_take[r_head]   : 1'b0;
  assign bus.out_target_pc   = w_vld ? r_target[r_head] : '0;
  assign bus.out_dest_value  = w_vld ? r_dval[r_head]   : '0;
  assign bus.out_dest_pr     = w_vld ? r_dpr[r_head]    : '0;
  assign bus.out_rob_entry   = w_vld ? r_rob[r_head]    : '0;
  assign bus.out_halt        = w_vld ? r_halt[r_head]   : 1'b0;

`ifdef BRANCH_FU_PREDICT_EN
  // Only the verdict matters downstream, so it is decided once at accept.
  logic r_misp [DEPTH];
  logic w_misp;
  assign w_misp = (w_take != bus.in_pred_taken) |
                  (w_take & (w_target != bus.in_pred_target));

  always_ff @(posedge clock) begin
    if (w_acc) r_misp[r_tail] <= w_misp;
  end

  assign bus.out_mispredict = w_vld ? r_misp[r_head] : 1'b0;
`else
  // No prediction inputs exist, so no per-entry prediction state is kept.
`endif
endmodule

// File: tb/tb_branch_fu_queue.sv
// Self-checking bench for branch_fu_queue: directed plan steps then random traffic vs a FIFO model.
module tb_branch_fu_queue;
  localparam int XLEN = 32, DEPTH = 2, ROB_W = 5, PR_W = 6;

  typedef struct packed {
    logic [2:0]  func;
    logic [31:0] pc, npc, imm, rs1, rs2;
    logic [5:0]  dpr;
    logic [4:0]  rob;
    logic        halt;
    logic        pt;
    logic [31:0] ptgt;
  } op_t;

  typedef struct packed {
    logic        take;
    logic [31:0] target, dval;
    logic [5:0]  dpr;
    logic [4:0]  rob;
    logic        halt;
    logic        misp;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0, n_cmp = 0, n_err = 0;
  exp_t q[$];

  branch_fu_queue_if #(.XLEN(XLEN), .ROB_W(ROB_W), .PR_W(PR_W)) bus ();

  branch_fu_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .ROB_W(ROB_W), .PR_W(PR_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  function automatic op_t mk(input logic [2:0] f, input logic [31:0] pc, npc, imm, rs1, rs2,
                             input logic [5:0] dpr, input logic [4:0] rob);
    op_t o;
    o = '0;
    o.func = f; o.pc = pc; o.npc = npc; o.imm = imm; o.rs1 = rs1; o.rs2 = rs2;
    o.dpr = dpr; o.rob = rob;
    return o;
  endfunction

  // Reference behaviour straight from the RISC-V branch rules.
  function automatic exp_t ref_res(input op_t o);
    exp_t e;
    bit t;
    case (o.func)
      3'd0: t = (o.rs1 == o.rs2);
      3'd1: t = (o.rs1 != o.rs2);
      3'd4: t = ($signed(o.rs1) < $signed(o.rs2));
      3'd5: t = ($signed(o.rs1) >= $signed(o.rs2));
      3'd6: t = (o.rs1 < o.rs2);
      3'd7: t = (o.rs1 >= o.rs2);
      default: t = 1'b1;
    endcase
    e.take   = t;
    e.target = (o.func == 3'd3) ? ((o.rs1 + o.imm) & ~32'h1) : (t ? o.pc + o.imm : o.npc);
    e.dval   = (o.func == 3'd2 || o.func == 3'd3) ? o.npc : 32'h0;
    e.dpr    = o.dpr;
    e.rob    = o.rob;
    e.halt   = o.halt;
    e.misp   = (t != o.pt) || (t && e.target != o.ptgt);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    e = (q.size() > 0) ? q[0] : '0;
    chk("in_ready",  64'(bus.in_ready),        64'(q.size() != DEPTH));
    chk("out_valid", 64'(bus.out_valid),       64'(q.size() != 0));
    chk("take",      64'(bus.out_take_branch), 64'(e.take));
    chk("target",    64'(bus.out_target_pc),   64'(e.target));
    chk("dest_val",  64'(bus.out_dest_value),  64'(e.dval));
    chk("dest_pr",   64'(bus.out_dest_pr),     64'(e.dpr));
    chk("rob",       64'(bus.out_rob_entry),   64'(e.rob));
    chk("halt",      64'(bus.out_halt),        64'(e.halt));
`ifdef BRANCH_FU_PREDICT_EN
    chk("mispredict", 64'(bus.out_mispredict), 64'(e.misp));
`endif
  endtask

  // Called at a negedge: check, drive the next cycle, advance the model, cross one posedge.
  task automatic cycle(input op_t o, input bit v, input bit st, input bit fl, input bit rs);
    bit acc, deq;
    check_outputs();
    reset              = rs;
    bus.in_valid       = v;
    bus.in_func        = o.func;
    bus.in_pc          = o.pc;
    bus.in_npc         = o.npc;
    bus.in_imm         = o.imm;
    bus.in_rs1         = o.rs1;
    bus.in_rs2         = o.rs2;
    bus.in_dest_pr     = o.dpr;
    bus.in_rob_entry   = o.rob;
    bus.in_halt        = o.halt;
    bus.complete_stall = st;
    bus.flush          = fl;
`ifdef BRANCH_FU_PREDICT_EN
    bus.in_pred_taken  = o.pt;
    bus.in_pred_target = o.ptgt;
`endif
    if (rs || fl) begin
      q.delete();
    end else begin
      acc = v && (q.size() != DEPTH);
      deq = (q.size() != 0) && !st;
      if (deq) void'(q.pop_front());
      if (acc) q.push_back(ref_res(o));
    end
    @(posedge clock);
    @(negedge clock);
    n_vec++;
  endtask

  initial begin
    op_t idle, o;
    idle = '0;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.complete_stall = 1'b0;
    bus.in_func = '0; bus.in_pc = '0; bus.in_npc = '0; bus.in_imm = '0;
    bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_dest_pr = '0; bus.in_rob_entry = '0; bus.in_halt = 1'b0;
`ifdef BRANCH_FU_PREDICT_EN
    bus.in_pred_taken = 1'b0; bus.in_pred_target = '0;
`endif
    repeat (2) @(posedge clock);
    @(negedge clock);

    // Reset state then idle
    cycle(idle, 0, 0, 0, 1);
    cycle(idle, 0, 0, 0, 0);

    // BNE taken, then held under stall for three cycles
    cycle(mk(3'd1, 32'h0, 32'h4, 32'h8, 32'h0, 32'd144, 6'd32, 5'd0), 1, 0, 0, 0);
    chk("bne_valid",  64'(bus.out_valid), 64'd1);
    chk("bne_take",   64'(bus.out_take_branch), 64'd1);
    chk("bne_target", 64'(bus.out_target_pc), 64'h8);
    chk("bne_dval",   64'(bus.out_dest_value), 64'h0);
    chk("bne_dpr",    64'(bus.out_dest_pr), 64'd32);
    repeat (3) begin
      cycle(idle, 0, 1, 0, 0);
      chk("stall_target", 64'(bus.out_target_pc), 64'h8);
    end
    cycle(idle, 0, 0, 0, 0);
    chk("drained", 64'(bus.out_valid), 64'd0);

    // Fill to DEPTH under stall, third op held off, then drain in order
    cycle(mk(3'd4, 32'h100, 32'h104, 32'h20, 32'hFFFF_FFFF, 32'h1, 6'd1, 5'd1), 1, 1, 0, 0);
    cycle(mk(3'd6, 32'h100, 32'h104, 32'h20, 32'hFFFF_FFFF, 32'h1, 6'd2, 5'd2), 1, 1, 0, 0);
    chk("full_ready", 64'(bus.in_ready), 64'd0);
    o = mk(3'd2, 32'h200, 32'h204, 32'h40, 32'h0, 32'h0, 6'd3, 5'd3);
    cycle(o, 1, 1, 0, 0);
    chk("blt_take", 64'(bus.out_take_branch), 64'd1);
    chk("blt_target", 64'(bus.out_target_pc), 64'h120);
    cycle(o, 1, 0, 0, 0);
    chk("bltu_take", 64'(bus.out_take_branch), 64'd0);
    chk("bltu_target", 64'(bus.out_target_pc), 64'h104);
    cycle(o, 1, 0, 0, 0);
    chk("jal_dval", 64'(bus.out_dest_value), 64'h204);
    chk("jal_target", 64'(bus.out_target_pc), 64'h240);
    cycle(idle, 0, 0, 0, 0);

    // JALR clears bit 0 of the target
    cycle(mk(3'd3, 32'h300, 32'h304, 32'h4, 32'h1001, 32'h0, 6'd4, 5'd4), 1, 0, 0, 0);
    chk("jalr_target", 64'(bus.out_target_pc), 64'h1004);
    chk("jalr_dval",   64'(bus.out_dest_value), 64'h304);

    // Flush with two queued and a valid input
    cycle(mk(3'd0, 32'h10, 32'h14, 32'h8, 32'h5, 32'h5, 6'd5, 5'd5), 1, 1, 0, 0);
    cycle(mk(3'd0, 32'h20, 32'h24, 32'h8, 32'h5, 32'h5, 6'd6, 5'd6), 1, 1, 0, 0);
    cycle(mk(3'd2, 32'h30, 32'h34, 32'h8, 32'h0, 32'h0, 6'd7, 5'd7), 1, 0, 1, 0);
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_ready", 64'(bus.in_ready), 64'd1);

    // Reset mid-operation wins over flush
    cycle(mk(3'd5, 32'h40, 32'h44, 32'h8, 32'h1, 32'h1, 6'd8, 5'd8), 1, 1, 0, 0);
    cycle(mk(3'd7, 32'h50, 32'h54, 32'h8, 32'h1, 32'h2, 6'd9, 5'd9), 1, 1, 0, 0);
    cycle(idle, 1, 0, 1, 1);
    chk("reset_valid", 64'(bus.out_valid), 64'd0);
    cycle(idle, 0, 0, 0, 0);

`ifdef BRANCH_FU_PREDICT_EN
    o = mk(3'd0, 32'h20, 32'h24, 32'h20, 32'h5, 32'h5, 6'd10, 5'd10);
    o.pt = 1'b1; o.ptgt = 32'h44;
    cycle(o, 1, 0, 0, 0);
    chk("misp_wrong_tgt", 64'(bus.out_mispredict), 64'd1);
    o.ptgt = 32'h40;
    cycle(o, 1, 0, 0, 0);
    chk("misp_right_tgt", 64'(bus.out_mispredict), 64'd0);
    cycle(idle, 0, 0, 0, 0);
`endif

    // Random traffic against the FIFO model
    for (int i = 0; i < 600; i++) begin
      bit [2:0] f;
      f = 3'($urandom_range(0, 7));
      o = mk(f, $urandom, $urandom, $urandom,
             ($urandom_range(0, 3) == 0) ? 32'(0 - $urandom_range(0, 3)) : $urandom,
             $urandom, 6'($urandom), 5'($urandom));
      if ($urandom_range(0, 3) == 0) o.rs2 = o.rs1;
      o.halt = ($urandom_range(0, 15) == 0);
      o.pt   = $urandom_range(0, 1);
      o.ptgt = ($urandom_range(0, 1) == 0) ? ref_res(o).target : $urandom;
      cycle(o, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 31) == 0), ($urandom_range(0, 63) == 0));
    end
    cycle(idle, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/branch_fu_queue.md
# branch_fu_queue

Parametrised branch functional unit with an in-order completion queue, next to the ALU/mult FUs between issue and complete. Resolves RISC-V conditional branches, JAL and JALR in the accept cycle, buffers up to DEPTH resolved results, and presents them to the complete stage one per cycle under a stall handshake. Supports a pipeline flush that squashes every buffered result.

## Interface
- XLEN, 32: datapath and PC width
- DEPTH, 2: queue entries (power of two, ≥1)
- ROB_W, 5: ROB index width
- PR_W, 6: physical register index width

- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  issue offers an op
- in_func  in  3  funct3 for branches (0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU); 2 JAL, 3 JALR
- in_pc, in_npc, in_imm, in_rs1, in_rs2  in  XLEN each  operands
- in_dest_pr  in  PR_W;  in_rob_entry  in  ROB_W;  in_halt  in  1
- in_ready  out  1  FU can accept (fu_ready)
- flush  in  1  squash all entries
- complete_stall  in  1  complete stage refuses head this cycle
- out_valid  out  1  head valid (want_to_complete)
- out_take_branch  out  1;  out_target_pc  out  XLEN;  out_dest_value  out  XLEN
- out_dest_pr  out  PR_W;  out_rob_entry  out  ROB_W;  out_halt  out  1

## Operation
- Accept = in_valid & in_ready & !flush. Result computed combinationally, written to tail entry.
- Conditions: BEQ rs1==rs2; BNE !=; BLT/BGE signed; BLTU/BGEU unsigned. JAL/JALR always taken.
- Target: branches and JAL pc+imm; JALR (rs1+imm) & ~1. Modulo 2^XLEN, carry discarded.
- out_dest_value = in_npc for JAL/JALR, 0 for branches. dest_pr, rob_entry, halt pass through.
- Not-taken branch: target_pc = in_npc.
- Head dequeued when out_valid & !complete_stall. Order strictly FIFO.
- Pointers: head, tail each log2(DEPTH) bits, wrap modulo DEPTH; count 0..DEPTH.
- in_ready = (count != DEPTH), from registered state only; no combinational path from complete_stall or in_valid.
- Full + dequeue same cycle: no accept that cycle (in_ready already 0).
- Empty: out_valid=0, all out_* fields driven 0.
- flush: next cycle count=0, head=tail=0; same-cycle accept and dequeue suppressed (a head shown during flush cycle is not considered completed).
- Illegal in_func: none (all 8 codes defined).

## Timing
- Reset: count=0, pointers 0, in_ready=1, out_valid=0, all out_* 0.
- Latency: accept in cycle N → out_valid in cycle N+1.
- Throughput: 1 op/cycle when complete_stall=0 and DEPTH≥2; DEPTH=1 gives one op every 2 cycles under back-to-back issue.
- Stalled head holds all out_* stable until dequeued or flushed.
- Reset mid-operation discards all entries identically to flush, and wins over flush.

## Configuration
- BRANCH_FU_PREDICT_EN defined: adds inputs in_pred_taken (1) and in_pred_target (XLEN), stored per entry; adds output out_mispredict (1) = (take != pred_taken) | (take & target != pred_target), 0 when empty/reset.
- Undefined: those ports and storage do not exist; behaviour otherwise identical.

## Test plan
- Reset then idle → in_ready=1, out_valid=0, all outputs 0.
- BNE pc=0, npc=4, imm=8, rs1=0, rs2=144, dest_pr=32, rob=0 → next cycle out_valid=1, take=1, target=8, dest_value=0, dest_pr=32.
- Same op held with complete_stall=1 for 3 cycles, then 0 → outputs stable 3 cycles, dequeued on 4th, out_valid=0 after.
- DEPTH=2, stall=1, issue 3 ops (BLT rs1=0xFFFFFFFF rs2=1 taken; BLTU same operands not-taken, target=npc; JAL) → in_ready=0 after 2 accepts, third held; release stall → results in order, JAL dest_value=npc.
- JALR rs1=0x1001, imm=4 → target=0x1004; flush with 2 entries queued and valid input → next cycle count=0, out_valid=0, input dropped.
- With BRANCH_FU_PREDICT_EN: BEQ taken target 0x40, pred_taken=1, pred_target=0x44 → out_mispredict=1; pred_target=0x40 → 0.
